// File: rtl/shiftreg_serialrx_pkg.sv
// shiftreg_serialrx_pkg: state encoding and default frame length for the serial receiver
package shiftreg_serialrx_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_e;
  localparam int N_DEFAULT = 9;
endpackage

// File: rtl/shiftreg_serialrx_if.sv
// shiftreg_serialrx_if: valid/ready word output port of the serial receiver
interface shiftreg_serialrx_if #(parameter int N = shiftreg_serialrx_pkg::N_DEFAULT);
  logic [N-2:0] dout;
  logic         dout_valid;
  logic         dout_ready;
  modport master(output dout, dout_valid, input dout_ready);
  modport slave(input dout, dout_valid, output dout_ready);
endinterface

// File: rtl/shiftreg_serialrx_outbuf.sv
// shiftreg_serialrx_outbuf: one-word holding register with valid/ready handshake and overrun pulse
module shiftreg_serialrx_outbuf #(parameter int W = 8) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  input  logic         dout_ready,
  output logic [W-1:0] dout,
  output logic         dout_valid,
  output logic         overrun
);
  logic [W-1:0] dout_q, dout_d;
  logic         valid_q, valid_d, ovr_q, ovr_d, load;
  // A word is taken when the slot is empty or is being emptied on this same edge
  always_comb begin
    load    = wr && (!valid_q || dout_ready);
    dout_d  = load ? wdata : dout_q;
    valid_d = load || (valid_q && !dout_ready);
    ovr_d   = wr && !load;
  end
  // Holding register state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end
  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign overrun    = ovr_q;
endmodule

// File: rtl/shiftreg_serialrx.sv
// shiftreg_serialrx: serial-in parallel-out frame receiver; SHIFTREG_SERIALRX_STOPCHK_EN adds a stop-bit check
module shiftreg_serialrx
  import shiftreg_serialrx_pkg::*;
#(parameter int N = N_DEFAULT) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   shift_en,
  input  logic                   sin,
  shiftreg_serialrx_if.master    out,
  output logic                   busy,
  output logic                   overrun,
  output logic                   frame_err
);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 2);
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-2:0]  shreg_q, shreg_d;
  logic          wr;
`ifdef SHIFTREG_SERIALRX_STOPCHK_EN
  logic          ferr_q, ferr_d;
`endif
  // Frame FSM: start detect, data shifting, optional stop-bit check; frozen when shift_en is low
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    wr      = 1'b0;
`ifdef SHIFTREG_SERIALRX_STOPCHK_EN
    ferr_d  = 1'b0;
`endif
    if (shift_en) begin
      case (state_q)
        IDLE: begin
          state_d = sin ? IDLE : DATA;
          cnt_d   = '0;
        end
        DATA: begin
          shreg_d = {shreg_q[N-3:0], sin};
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            cnt_d = '0;
`ifdef SHIFTREG_SERIALRX_STOPCHK_EN
            state_d = STOP;
`else
            state_d = IDLE;
            wr      = 1'b1;
`endif
          end
        end
`ifdef SHIFTREG_SERIALRX_STOPCHK_EN
        STOP: begin
          state_d = IDLE;
          wr      = sin;
          ferr_d  = !sin;
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end
  // FSM, counter and shift register state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end
`ifdef SHIFTREG_SERIALRX_STOPCHK_EN
  // Registered one-cycle frame error pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ferr_q <= 1'b0;
    else        ferr_q <= ferr_d;
  end
  assign frame_err = ferr_q;
`else
  assign frame_err = 1'b0;
`endif
  assign busy = state_q != IDLE;
  shiftreg_serialrx_outbuf #(.W(N - 1)) u_outbuf (
    .clk        (clk),
    .reset      (reset),
    .wr         (wr),
    .wdata      (shreg_d),
    .dout_ready (out.dout_ready),
    .dout       (out.dout),
    .dout_valid (out.dout_valid),
    .overrun    (overrun)
  );
endmodule

// File: tb/tb_shiftreg_serialrx.sv
// tb_shiftreg_serialrx: directed scoreboard bench for shiftreg_serialrx (N=9)
module tb_shiftreg_serialrx;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic shift_en = 1'b1;
  logic sin = 1'b1;
  logic busy, overrun, frame_err;
  int   tests = 0;
  int   fails = 0;
  int   ovr_seen = 0;
  logic [7:0] sb[$];

  shiftreg_serialrx_if #(.N(9)) bus();

  shiftreg_serialrx #(.N(9)) dut (
    .clk       (clk),
    .reset     (reset),
    .shift_en  (shift_en),
    .sin       (sin),
    .out       (bus),
    .busy      (busy),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    ovr_seen += int'(overrun);
    if (bus.dout_valid && bus.dout_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL sb_unexpected: observed %0h expected no word", bus.dout);
      end else check("sb_word", 32'(bus.dout), 32'(sb.pop_front()));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic stop, input logic ready_last, input logic chk);
    logic [8:0] bits;
    int nb;
    bits = {1'b0, d};
`ifdef SHIFTREG_SERIALRX_STOPCHK_EN
    nb = 10;
`else
    nb = 9;
`endif
    for (int i = 0; i < nb; i++) begin
      sin = (i < 9) ? bits[8-i] : stop;
      if (i == nb - 1 && ready_last) bus.dout_ready = 1'b1;
      tick();
      if (chk && i < nb - 1) begin
        check("busy_mid", 32'(busy), 32'd1);
        check("valid_early", 32'(bus.dout_valid), 32'd0);
      end
    end
    sin = 1'b1;
    if (ready_last) bus.dout_ready = 1'b0;
  endtask

  initial begin
    bus.dout_ready = 1'b0;
    #1;
    check("rst_dout", 32'(bus.dout), 32'd0);
    check("rst_valid", 32'(bus.dout_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_valid", 32'(bus.dout_valid), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_dout", 32'(bus.dout), 32'd0);
    end

    bus.dout_ready = 1'b1;
    sb.push_back(8'hA5);
    send(8'hA5, 1'b1, 1'b0, 1'b1);
    check("a5_valid", 32'(bus.dout_valid), 32'd1);
    check("a5_dout", 32'(bus.dout), 32'hA5);
    check("a5_busy", 32'(busy), 32'd0);
    tick();
    check("a5_valid_fall", 32'(bus.dout_valid), 32'd0);
    bus.dout_ready = 1'b0;
    tick();

    ovr_seen = 0;
    sb.push_back(8'h3C);
    send(8'h3C, 1'b1, 1'b0, 1'b0);
    send(8'hC3, 1'b1, 1'b0, 1'b0);
    check("ovr_pulse", 32'(overrun), 32'd1);
    check("ovr_dout", 32'(bus.dout), 32'h3C);
    check("ovr_valid", 32'(bus.dout_valid), 32'd1);
    tick();
    check("ovr_pulse_end", 32'(overrun), 32'd0);
    bus.dout_ready = 1'b1;
    tick();
    bus.dout_ready = 1'b0;
    check("ovr_accept_valid", 32'(bus.dout_valid), 32'd0);
    tick();
    check("ovr_count", 32'(ovr_seen), 32'd1);

    ovr_seen = 0;
    sb.push_back(8'h3C);
    sb.push_back(8'hC3);
    send(8'h3C, 1'b1, 1'b0, 1'b0);
    send(8'hC3, 1'b1, 1'b1, 1'b0);
    check("swap_dout", 32'(bus.dout), 32'hC3);
    check("swap_valid", 32'(bus.dout_valid), 32'd1);
    check("swap_ovr", 32'(overrun), 32'd0);
    bus.dout_ready = 1'b1;
    tick();
    bus.dout_ready = 1'b0;
    check("swap_drain", 32'(bus.dout_valid), 32'd0);
    tick();
    check("swap_ovr_count", 32'(ovr_seen), 32'd0);

    sin = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      sin = 1'b1;
      tick();
    end
    check("abort_busy_pre", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(bus.dout_valid), 32'd0);
    check("abort_dout", 32'(bus.dout), 32'd0);
    check("abort_ovr", 32'(overrun), 32'd0);
    check("abort_ferr", 32'(frame_err), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("abort_idle_valid", 32'(bus.dout_valid), 32'd0);
    bus.dout_ready = 1'b1;
    sb.push_back(8'h01);
    send(8'h01, 1'b1, 1'b0, 1'b1);
    check("post_dout", 32'(bus.dout), 32'h01);
    check("post_valid", 32'(bus.dout_valid), 32'd1);
    tick();
    bus.dout_ready = 1'b0;
    tick();

`ifdef SHIFTREG_SERIALRX_STOPCHK_EN
    send(8'h5A, 1'b0, 1'b0, 1'b1);
    check("ferr_pulse", 32'(frame_err), 32'd1);
    check("ferr_valid", 32'(bus.dout_valid), 32'd0);
    check("ferr_busy", 32'(busy), 32'd0);
    tick();
    check("ferr_pulse_end", 32'(frame_err), 32'd0);
    check("ferr_idle", 32'(busy), 32'd0);
    check("ferr_valid_after", 32'(bus.dout_valid), 32'd0);
`endif

    check("sb_left", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/shiftreg_serialrx.md
# shiftreg_serialrx

Serial-in, parallel-out frame receiver that consumes the one-bit `sout` stream of the parallel-load shift-register transmitter. It detects the leading 0 start bit and shifts in N-1 data bits MSB first. It presents the recovered word on a valid/ready output port with a one-word holding register, and flags overrun. It sits directly downstream of the transmitter on the same clock, with one bit per enabled cycle.

## Interface
- `N`, default 9: frame length in bits, counting the start bit. Data width is N-1.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset. Low clears all state immediately.
- `shift_en` in 1: bit strobe. `sin` is sampled only on edges where this is 1. Tie to 1 for one bit per clock.
- `sin` in 1: serial line. Idles at 1; start bit is 0.
- `dout` out N-1: received word, first data bit in `dout[N-2]`.
- `dout_valid` out 1: `dout` holds an unconsumed word.
- `dout_ready` in 1: consumer accepts `dout` when both `dout_valid` and `dout_ready` are 1.
- `busy` out 1: a frame is in progress (state is not IDLE).
- `overrun` out 1: one-cycle pulse when a completed word is dropped.
- `frame_err` out 1: one-cycle pulse on a bad stop bit. Present only with the stop-check macro; otherwise tied to 0.

## Operation
- States: IDLE, DATA, STOP. STOP exists only with the stop-check macro.
- IDLE:
  - `shift_en` & `sin`=0 → DATA, with bit counter cleared to 0.
  - `sin`=1 → stay in IDLE.
- DATA:
  - Each enabled edge does shreg <= {shreg[N-3:0], sin} and increments the counter.
  - After N-1 data bits, the frame is complete: go to IDLE, or to STOP with the macro.
- Completion (delivery):
  - If `dout_valid`=0, or (`dout_valid`=1 and `dout_ready`=1): `dout` <= shreg and `dout_valid` <= 1.
  - Else the new word is dropped, `dout` is unchanged, and `overrun` pulses for one cycle.
- Handshake: `dout_valid` clears on the accepting edge unless a new word is delivered on that same edge. `dout` is stable while `dout_valid`=1.
- Cycles with `shift_en`=0 freeze the state and counter. The handshake still operates on those cycles.
- Counter width: $clog2(N). The counter never exceeds N-2.
- Reset values: `dout`=0, `dout_valid`=0, `busy`=0, `overrun`=0, `frame_err`=0, state IDLE, counter 0, shreg 0.
- Reset mid-frame aborts the partial word. Nothing is delivered.

## Timing
- With `shift_en`=1 continuously and the start bit sampled at edge 0, data bits are sampled at edges 1..N-1.
- Without the macro: `dout_valid` rises after edge N-1, i.e. 9 cycles after the start bit for N=9.
- With the macro: the stop bit is sampled at edge N, and `dout_valid` rises after edge N.
- Back-to-back frames:
  - Without the macro, the next start bit may be sampled at edge N. Minimum spacing is N bits.
  - With the macro, minimum spacing is N+1 bits.
- `busy` is 1 from the edge after the start bit until the frame completes.
- `overrun` and `frame_err` are registered and high for exactly one cycle.

## Configuration
- Macro: `SHIFTREG_SERIALRX_STOPCHK_EN`.
- Defined:
  - After the data bits, the STOP state samples one more bit.
  - Stop bit 1: the word is delivered as in Operation.
  - Stop bit 0: the word is discarded, `frame_err` pulses, and the state returns to IDLE. That 0 is not treated as a start bit.
- Undefined: no STOP state, no stop bit, and `frame_err` is constant 0.

## Structure
- Package `shiftreg_serialrx_pkg` holds:
  - the state encoding (IDLE=2'd0, DATA=2'd1, STOP=2'd2);
  - the default frame length constant.
- Sub-module `shiftreg_serialrx_outbuf` implements the one-word holding register:
  - inputs `wr` and `wdata`;
  - `dout`, `dout_valid` and `dout_ready`;
  - an overrun pulse output.
- The FSM, counter and shift register stay in the top module.

## Test plan
- Reset, then hold `sin`=1 for 20 cycles → `dout_valid`=0, `busy`=0, `dout`=0 throughout.
- Transmitter loads d=8'hA5, giving line bits 0,1,0,1,0,0,1,0,1 then 1s; `dout_ready`=1 → `dout`=8'hA5 and `dout_valid` high for one cycle. It rises 9 edges after the start bit, or 10 edges with the macro.
- Two frames, 8'h3C then 8'hC3, with minimum spacing and `dout_ready`=0 → first word held at 8'h3C, second dropped, `overrun` pulses once. Then raise `dout_ready` → 8'h3C is accepted and `dout_valid` falls.
- Same two frames with `dout_ready` pulsed on the exact completion edge of the second frame → 8'h3C is consumed and `dout`=8'hC3 with `dout_valid` still 1.
- Assert `reset` low after the 4th data bit of 8'hFF → all outputs return to reset values immediately. The next frame, 8'h01, is received correctly.
- Macro defined, stop bit forced to 0 on a frame carrying 8'h5A → `frame_err` pulses one cycle, `dout_valid` stays 0, state returns to IDLE.
